// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter and word sequencer that shares one
// serial transmitter among N_REQ requesters, with a completion watchdog.
//
// Ports:
//   clock, reset : system clock; asynchronous active-high reset
//   req          : level request per requester, sampled only in IDLE
//   len          : packed word counts, requester i at [i*LEN_W +: LEN_W]
//   tx_pronto    : transmitter pulse, current word fully sent
//   tx_partida   : one-cycle start pulse to the transmitter
//   grant, sel   : one-hot grant and its index (data mux select)
//   indice       : index of the word being sent within the message
//   done         : one-cycle pulse to the requester whose message completed
//   erro         : one-cycle pulse when the watchdog aborts a transfer
//   ocupado      : high in every state except IDLE
module serial_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int SEL_W   = 2,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 1024,
  parameter int TMR_W   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic                   tx_pronto,
  output logic                   tx_partida,
  output logic [N_REQ-1:0]       grant,
  output logic [SEL_W-1:0]       sel,
  output logic [LEN_W-1:0]       indice,
  output logic [N_REQ-1:0]       done,
  output logic                   erro,
  output logic                   ocupado
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PREPARA    = 3'd1,
    S_TRANSMITE  = 3'd2,
    S_INCREMENTA = 3'd3,
    S_LIBERA     = 3'd4,
    S_ERRO       = 3'd5
  } state_t;

  localparam logic [N_REQ-1:0] ONE =
    {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [N_REQ-1:0] r_grant;
  logic [LEN_W-1:0] r_indice;
  logic [LEN_W-1:0] r_len_q;
  logic [TMR_W-1:0] r_timer;

  logic             w_any;
  logic             w_hit;
  logic [SEL_W-1:0] w_cand;
  logic [SEL_W-1:0] w_win;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [LEN_W-1:0] w_win_len;
  logic             w_tmo;
  logic             w_last;

  // (a + b) mod N_REQ for a < N_REQ and 0 <= b < N_REQ
  function automatic logic [SEL_W-1:0] wrap_add(
    input logic [SEL_W-1:0] a,
    input int               b
  );
    int s;
    s = int'(a) + b;
    if (s >= N_REQ) s = s - N_REQ;
    return SEL_W'(s);
  endfunction

  assign w_any     = |req;
  assign w_sel_nxt = wrap_add(r_sel, 1);
  assign w_tmo     = (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_last    = (r_indice == r_len_q - 1'b1);

  // First set request searching upward from the pointer, with wrap
  always_comb begin
    w_win  = '0;
    w_hit  = 1'b0;
    w_cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = wrap_add(r_ptr, i);
      if (!w_hit && req[w_cand]) begin
        w_win = w_cand;
        w_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_win_len = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == SEL_W'(i))
        w_win_len = len[i*LEN_W +: LEN_W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // A pronto coinciding with the last watchdog cycle still completes the word
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any)
          w_next = (w_win_len == '0) ? S_LIBERA : S_PREPARA;
      end
      S_PREPARA:   w_next = S_TRANSMITE;
      S_TRANSMITE: begin
        if (tx_pronto)  w_next = S_INCREMENTA;
        else if (w_tmo) w_next = S_ERRO;
      end
      S_INCREMENTA: w_next = w_last ? S_LIBERA : S_PREPARA;
      S_LIBERA:     w_next = S_IDLE;
      S_ERRO:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_partida = 1'b0;
    done       = '0;
    erro       = 1'b0;
    ocupado    = 1'b0;
    case (r_state)
      S_PREPARA: begin
        tx_partida = 1'b1;
        ocupado    = 1'b1;
      end
      S_TRANSMITE:  ocupado = 1'b1;
      S_INCREMENTA: ocupado = 1'b1;
      S_LIBERA: begin
        done    = ONE << r_sel;
        ocupado = 1'b1;
      end
      S_ERRO: begin
        erro    = 1'b1;
        ocupado = 1'b1;
      end
      default: begin
        tx_partida = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_sel    <= '0;
      r_grant  <= '0;
      r_indice <= '0;
      r_len_q  <= '0;
      r_timer  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel    <= w_win;
            r_grant  <= ONE << w_win;
            r_len_q  <= w_win_len;
            r_indice <= '0;
          end
        end
        S_PREPARA: r_timer <= '0;
        S_TRANSMITE: begin
          if (!tx_pronto) r_timer <= r_timer + 1'b1;
        end
        S_INCREMENTA: begin
          if (!w_last) r_indice <= r_indice + 1'b1;
        end
        S_LIBERA, S_ERRO: begin
          r_ptr   <= w_sel_nxt;
          r_grant <= '0;
        end
        default: r_grant <= '0;
      endcase
    end
  end

  assign grant  = r_grant;
  assign sel    = r_sel;
  assign indice = r_indice;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: scoreboard bench for serial_tx_arbiter.
// Transaction-level model predicts start/done/erro events and their spacing.
module tb_serial_tx_arbiter;

  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int LW  = 4;
  localparam int TMO = 8;
  localparam int TW  = 3;

  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERRO  = 2;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*LW-1:0] len;
  logic            tx_pronto;
  logic            tx_partida;
  logic [N-1:0]    grant;
  logic [SW-1:0]   sel;
  logic [LW-1:0]   indice;
  logic [N-1:0]    done;
  logic            erro;
  logic            ocupado;

  serial_tx_arbiter #(
    .N_REQ(N), .SEL_W(SW), .LEN_W(LW),
    .TIMEOUT(TMO), .TMR_W(TW)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .len(len),
    .tx_pronto(tx_pronto), .tx_partida(tx_partida),
    .grant(grant), .sel(sel), .indice(indice),
    .done(done), .erro(erro), .ocupado(ocupado)
  );

  typedef struct {
    int kind;
    int r;
    int idx;
    int gap;
  } ev_t;

  ev_t exp_q[$];
  int  dly_q[$];
  int  errors   = 0;
  int  checks   = 0;
  int  cyc      = 0;
  int  last_cyc = 0;
  int  m_ptr    = 0;
  int  npart    = 0;
  int  hook5    = 0;
  int  mlen[N][8];
  int  mcnt[N];
  int  mhead[N];
  bit  drop[N];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: pop one expected event per observed DUT event
  initial begin
    ev_t e;
    int  k;
    forever begin
      @(negedge clock);
      if (!reset && (tx_partida || done != '0 || erro)) begin
        k = tx_partida ? K_START : (erro ? K_ERRO : K_DONE);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", k, -1);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind", k, e.kind);
          chk("ev_sel", longint'(sel), e.r);
          chk("ev_grant", longint'(grant), longint'(1 << e.r));
          chk("ev_gap", cyc - last_cyc, e.gap);
          if (e.kind == K_START)
            chk("ev_indice", longint'(indice), e.idx);
          else
            chk("ev_done", longint'(done),
                e.kind == K_DONE ? longint'(1 << e.r) : 0);
        end
        last_cyc = cyc;
      end
    end
  end

  // Transmitter model: d>0 pronto d cycles after start, 0 pronto during
  // the start cycle itself, -1 never
  initial begin
    int d;
    tx_pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && tx_partida) begin
        d = (dly_q.size() > 0) ? dly_q.pop_front() : -1;
        if (d == 0) begin
          tx_pronto = 1'b1;
          @(negedge clock);
          tx_pronto = 1'b0;
        end else if (d > 0) begin
          repeat (d) @(negedge clock);
          tx_pronto = 1'b1;
          @(negedge clock);
          tx_pronto = 1'b0;
        end
      end
    end
  end

  function automatic int pick_delay(int mode);
    int r;
    if (mode != -2) return mode;
    r = $urandom_range(0, 19);
    if (r == 0) return -1;
    if (r == 1) return 0;
    return $urandom_range(1, 8);
  endfunction

  // Expected events of one message; gap0 = spacing of its first event
  function automatic void push_txn(int r, int l, int mode, int gap0);
    int g;
    int d;
    g = gap0;
    if (l == 0) begin
      exp_q.push_back('{K_DONE, r, 0, g});
      return;
    end
    for (int w = 0; w < l; w++) begin
      d = pick_delay(mode);
      exp_q.push_back('{K_START, r, w, g});
      dly_q.push_back(d);
      if (d <= 0) begin
        exp_q.push_back('{K_ERRO, r, 0, TMO + 1});
        return;
      end
      g = d + 2;
    end
    exp_q.push_back('{K_DONE, r, 0, g});
  endfunction

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i] = (mhead[i] < mcnt[i]) && !drop[i];
      len[i*LW +: LW] = (mhead[i] < mcnt[i]) ?
                        LW'(mlen[i][mhead[i]]) : '0;
    end
  endtask

  task automatic clear_msgs();
    for (int i = 0; i < N; i++) begin
      mcnt[i]  = 0;
      mhead[i] = 0;
      drop[i]  = 1'b0;
    end
    npart = 0;
    hook5 = 0;
  endtask

  // Requester agents: retire a message on its done/erro
  task automatic agent_step();
    if (tx_partida) npart++;
    if (hook5 != 0 && npart == 2) begin
      drop[0]          = 1'b1;
      mlen[3][mcnt[3]] = 1;
      mcnt[3]++;
      hook5 = 0;
    end
    for (int i = 0; i < N; i++)
      if (done[i] || (erro && grant[i])) mhead[i]++;
    drive_req();
  endtask

  function automatic bit all_served();
    for (int i = 0; i < N; i++)
      if (mhead[i] < mcnt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic hard_reset();
    reset = 1'b1;
    clear_msgs();
    drive_req();
    exp_q.delete();
    dly_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_ptr = 0;
    @(negedge clock);
  endtask

  task automatic wait_phase();
    int t;
    t = 0;
    while (!(all_served() && exp_q.size() == 0) && t < 3000) begin
      @(negedge clock);
      agent_step();
      t++;
    end
    chk("phase_complete", t < 3000, 1);
    if (t >= 3000) hard_reset();
    repeat (3) @(negedge clock);
    chk("idle_outputs",
        longint'({ocupado, grant, tx_partida, erro, done}), 0);
    chk("delays_left", dly_q.size(), 0);
  endtask

  // Model: serve loaded messages in round-robin order from m_ptr
  task automatic run_phase(int mode);
    int hd[N];
    int w;
    int i;
    int g;
    for (int k = 0; k < N; k++) hd[k] = 0;
    g = 1;
    while (1) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (w < 0 && hd[i] < mcnt[i]) w = i;
      end
      if (w < 0) break;
      push_txn(w, mlen[w][hd[w]], mode, g);
      hd[w]++;
      m_ptr = (w + 1) % N;
      g = 2;
    end
    last_cyc = cyc;
    drive_req();
    wait_phase();
  endtask

  task automatic one_msg(int r, int l);
    mlen[r][mcnt[r]] = l;
    mcnt[r]++;
  endtask

  initial begin
    int t;
    reset = 1'b1;
    req   = '0;
    len   = '0;
    clear_msgs();
    #2;
    chk("reset_outputs",
        longint'({ocupado, grant, sel, indice, tx_partida, erro, done}), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_after_reset",
        longint'({ocupado, grant, sel, indice, tx_partida}), 0);

    // all requesting, len 1, prompt pronto
    clear_msgs();
    one_msg(0, 1); one_msg(0, 1);
    one_msg(1, 1); one_msg(2, 1); one_msg(3, 1);
    run_phase(1);

    // three words, pronto 5 cycles after each start
    clear_msgs();
    one_msg(0, 3);
    run_phase(5);

    // zero-length message
    clear_msgs();
    one_msg(2, 0);
    run_phase(1);

    // pronto withheld: watchdog abort
    clear_msgs();
    one_msg(1, 2);
    run_phase(-1);

    // pronto on the last watchdog cycle, and pronto during the start cycle
    clear_msgs();
    one_msg(3, 2);
    run_phase(8);
    clear_msgs();
    one_msg(2, 1);
    run_phase(0);

    // req changes mid-transfer are ignored
    clear_msgs();
    one_msg(0, 4);
    hook5 = 1;
    push_txn(0, 4, 2, 1);
    push_txn(3, 1, 1, 2);
    m_ptr = 0;
    last_cyc = cyc;
    drive_req();
    wait_phase();

    for (int p = 0; p < 25; p++) begin
      clear_msgs();
      for (int i = 0; i < N; i++) begin
        mcnt[i] = $urandom_range(0, 2);
        for (int m = 0; m < mcnt[i]; m++)
          mlen[i][m] = $urandom_range(0, 5);
      end
      if (all_served()) one_msg($urandom_range(0, N - 1), 2);
      run_phase(-2);
    end

    // reset during TRANSMITE of word 2
    clear_msgs();
    one_msg(0, 4);
    exp_q.push_back('{K_START, 0, 0, 1});
    exp_q.push_back('{K_START, 0, 1, 4});
    exp_q.push_back('{K_START, 0, 2, 4});
    dly_q.push_back(2);
    dly_q.push_back(2);
    dly_q.push_back(-1);
    last_cyc = cyc;
    drive_req();
    t = 0;
    while (npart < 3 && t < 200) begin
      @(negedge clock);
      agent_step();
      t++;
    end
    chk("reached_word2", npart, 3);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        longint'({ocupado, grant, sel, indice, tx_partida, erro, done}), 0);
    chk("events_before_reset", exp_q.size(), 0);
    exp_q.delete();
    dly_q.delete();
    clear_msgs();
    drive_req();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_ptr = 0;
    repeat (2) @(negedge clock);

    // pointer back at 0: requester 0 first
    clear_msgs();
    one_msg(0, 1);
    one_msg(1, 1);
    run_phase(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
